// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, owner tags, rw and size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Access size codes, identical to the load/store unit's LS_B/LS_H/LS_W.
    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Winner pick between fetch (I) and load/store (D) requesters, D-priority with optional starvation guard.
// Latency: grants are combinational; the starvation counter updates on the clock edge.
// Backpressure: grants only while arb_en is high; a non-granted requester simply sees no grant. Macro: MEM_ARB_STARVE_GUARD_EN.
module arb_grant_sel #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
    input  logic i_vld,
    input  logic d_vld,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    // D wins unless I has been passed over STARVE_LIMIT times in a row; counter tracks those pass-overs
    always_comb begin
        starved      = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            if (i_vld && (starved || !d_vld)) begin
                grant_i = 1'b1;
            end else if (d_vld) begin
                grant_d = 1'b1;
            end
            if (grant_i || !i_vld) begin
                starve_cnt_d = '0;
            end else if (grant_d && !starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // starvation counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict D priority needs no state; clock and reset are intentionally idle here.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    // strict D-over-I priority
    always_comb begin
        grant_d = arb_en && d_vld;
        grant_i = arb_en && i_vld && !d_vld;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and load/store; one transaction in flight, owner-tagged responses.
// Latency: accept at T, m_req_valid at T+1, response at T+2 with a 0-wait memory; next accept the cycle after a response.
// Backpressure: readies only in IDLE (loser holds its request); payload held while m_req_ready is low. Macro: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_req_rw,
    input  logic [1:0]        d_req_size,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              m_req_valid,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic              m_req_rw,
    output logic [1:0]        m_req_size,
    input  logic              m_req_ready,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rsp_data,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q,    rw_d;
    logic [1:0]        size_q,  size_d;

    logic arb_en;
    logic grant_i;
    logic grant_d;
    logic rsp_hit;

    // Arbitration is only open in IDLE and never while reset is held.
    assign arb_en = (state_q == ARB_IDLE) && !reset;

    arb_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_sel (
        .clock   (clock),
        .reset   (reset),
        .arb_en  (arb_en),
        .i_vld   (i_req_valid),
        .d_vld   (d_req_valid),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // next state, payload capture on accept, and request-side handshakes
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        size_d      = size_q;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        m_req_valid = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    d_req_ready = 1'b1;
                    owner_d     = OWN_D;
                    addr_d      = d_req_addr;
                    wdata_d     = d_req_wdata;
                    rw_d        = d_req_rw;
                    size_d      = d_req_size;
                    state_d     = ARB_REQ;
                end else if (grant_i) begin
                    i_req_ready = 1'b1;
                    owner_d     = OWN_I;
                    addr_d      = i_req_addr;
                    wdata_d     = '0;
                    rw_d        = MEM_READ;
                    size_d      = LS_W;
                    state_d     = ARB_REQ;
                end
            end
            ARB_REQ: begin
                m_req_valid = !reset;
                if (m_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (m_rsp_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // response routing by owner; memory responses outside WAIT are ignored
    always_comb begin
        rsp_hit     = (state_q == ARB_WAIT) && m_rsp_valid && !reset;
        i_rsp_valid = rsp_hit && (owner_q == OWN_I);
        d_rsp_valid = rsp_hit && (owner_q == OWN_D);
        i_rsp_data  = m_rsp_data;
        d_rsp_data  = m_rsp_data;
    end

    assign m_req_addr  = addr_q;
    assign m_req_wdata = wdata_q;
    assign m_req_rw    = rw_q;
    assign m_req_size  = size_q;
    assign busy        = (state_q != ARB_IDLE);

    // state, owner and registered memory payload
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
// Latency: inputs driven at negedge+2, outputs sampled at negedge+3.
// Backpressure: requesters hold until accepted; memory stall/latency knobs randomized. Macro: MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_rsp_valid;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_rw, d_req_ready, d_rsp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [1:0]  d_req_size;
    logic        m_req_valid, m_req_rw, m_req_ready, m_rsp_valid;
    logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
    logic [1:0]  m_req_size;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_rw(d_req_rw), .d_req_size(d_req_size), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_req_rw(m_req_rw), .m_req_size(m_req_size), .m_req_ready(m_req_ready),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- memory environment ----------------
    int          stall_knob = 0, lat_knob = 0;
    bit          spur_knob = 1'b0;
    int          stall_left = 0, lat_left = 0;
    bit          stall_loaded = 1'b0, pend = 1'b0;
    logic [31:0] pend_addr, pend_wdata;
    logic        pend_rw;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = 32'h0;
    end

    // Memory: accepts after stall_knob cycles, answers lat_knob cycles after the earliest slot.
    always @(negedge clock) begin
        m_rsp_valid = 1'b0;
        m_rsp_data  = 32'hC0FF_EE00;
        if (pend) begin
            if (lat_left == 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = mem_read(pend_addr);
                if (pend_rw) mem_arr[pend_addr] = pend_wdata;
                pend = 1'b0;
            end else begin
                lat_left--;
            end
        end else if (spur_knob) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = 32'hBADB_AD00;
            spur_knob   = 1'b0;
        end
        m_req_ready = 1'b0;
        if (m_req_valid === 1'b1 && !pend) begin
            if (!stall_loaded) begin
                stall_left   = stall_knob;
                stall_loaded = 1'b1;
            end
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                m_req_ready  = 1'b1;
                pend         = 1'b1;
                lat_left     = lat_knob;
                pend_addr    = m_req_addr;
                pend_wdata   = m_req_wdata;
                pend_rw      = m_req_rw;
                stall_loaded = 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          have_txn = 1'b0, issued = 1'b0;
    bit          txn_owner;              // 0 = I, 1 = D
    logic [31:0] txn_addr, txn_wdata, txn_exp;
    logic        txn_rw;
    logic [1:0]  txn_size;
    int          starve_cnt = 0;
    int          cyc_n = 0, i_rsp_cnt = 0, d_rsp_cnt = 0, m_rsp_cnt = 0;
    bit          saw_i_acc, saw_d_acc, saw_i_rsp, saw_d_rsp;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        bit want_i, exp_ir, exp_dr, exp_irsp, exp_drsp, exp_mreq;
        cyc_n++;
        saw_i_acc = (i_req_valid && i_req_ready) === 1'b1;
        saw_d_acc = (d_req_valid && d_req_ready) === 1'b1;
        saw_i_rsp = i_rsp_valid === 1'b1;
        saw_d_rsp = d_rsp_valid === 1'b1;
        if (saw_i_rsp) i_rsp_cnt++;
        if (saw_d_rsp) d_rsp_cnt++;
        if (m_rsp_valid) m_rsp_cnt++;

        want_i = 1'b0; exp_ir = 1'b0; exp_dr = 1'b0;
        if (!reset && !have_txn) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            want_i = i_req_valid && (!d_req_valid || starve_cnt >= LIMIT);
`else
            want_i = i_req_valid && !d_req_valid;
`endif
            exp_ir = want_i;
            exp_dr = d_req_valid && !want_i;
        end
        chk("i_req_ready", i_req_ready, exp_ir);
        chk("d_req_ready", d_req_ready, exp_dr);

        exp_irsp = !reset && have_txn && issued && m_rsp_valid && !txn_owner;
        exp_drsp = !reset && have_txn && issued && m_rsp_valid && txn_owner;
        chk("i_rsp_valid", i_rsp_valid, exp_irsp);
        chk("d_rsp_valid", d_rsp_valid, exp_drsp);
        if (exp_irsp) chk("i_rsp_data", i_rsp_data, txn_exp);
        if (exp_drsp && !txn_rw) chk("d_rsp_data", d_rsp_data, txn_exp);

        exp_mreq = have_txn && !issued;
        if (!reset) begin
            chk("busy", busy, have_txn);
            chk("m_req_valid", m_req_valid, exp_mreq);
            if (exp_mreq) begin
                chk("m_req_addr", m_req_addr, txn_addr);
                chk("m_req_rw", m_req_rw, txn_rw);
                chk("m_req_size", m_req_size, txn_size);
                if (txn_owner) chk("m_req_wdata", m_req_wdata, txn_wdata);
            end
        end

        if (reset) begin
            have_txn = 1'b0; issued = 1'b0; starve_cnt = 0;
        end else if (exp_mreq) begin
            if (m_req_ready) issued = 1'b1;
        end else if (have_txn) begin
            if (m_rsp_valid) have_txn = 1'b0;
        end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (saw_i_acc || !i_req_valid) starve_cnt = 0;
            else if (saw_d_acc && starve_cnt < LIMIT) starve_cnt++;
`endif
            if (saw_d_acc) begin
                have_txn = 1'b1; issued = 1'b0; txn_owner = 1'b1;
                txn_addr = d_req_addr; txn_wdata = d_req_wdata;
                txn_rw = d_req_rw; txn_size = d_req_size;
                txn_exp = ref_read(d_req_addr);
                if (d_req_rw) ref_mem[d_req_addr] = d_req_wdata;
                grant_log.push_back(1);
            end else if (saw_i_acc) begin
                have_txn = 1'b1; issued = 1'b0; txn_owner = 1'b0;
                txn_addr = i_req_addr; txn_wdata = 32'h0;
                txn_rw = MEM_READ; txn_size = LS_W;
                txn_exp = ref_read(i_req_addr);
                grant_log.push_back(0);
            end
        end
    endtask

    task automatic cyc();
        #1;
        monitor();
        @(negedge clock);
        #2;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((have_txn || busy === 1'b1) && k < 60) begin
            cyc();
            k++;
        end
        chk(tag, have_txn, 1'b0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem_arr[a] = v;
        ref_mem[a] = v;
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        int k, i0, d0, m0, g0, rsp_at, acc_at;
        reset = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
        d_req_rw = 1'b0; d_req_size = LS_W;
        @(negedge clock); #2;

        // reset state, with requests raised to confirm no ready escapes
        cyc();
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_req_valid", m_req_valid, 1'b0);
        chk("rst_m_req_addr", m_req_addr, 32'h0);
        chk("rst_m_req_wdata", m_req_wdata, 32'h0);
        chk("rst_m_req_rw", m_req_rw, 1'b0);
        chk("rst_m_req_size", m_req_size, 2'b00);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        reset = 1'b0;
        cyc();

        // I-only fetch, 0-wait memory: ready at T, m_req at T+1, response at T+2
        preload(32'h0100_0000, 32'h0000_0013);
        i_req_valid = 1'b1; i_req_addr = 32'h0100_0000;
        cyc();
        chk("t1_accept_T", saw_i_acc, 1'b1);
        i_req_valid = 1'b0;
        chk("t1_m_req_T1", m_req_valid, 1'b1);
        cyc();
        chk("t1_rsp_T2", i_rsp_valid, 1'b1);
        chk("t1_rsp_data", i_rsp_data, 32'h0000_0013);
        drain("t1_drain");

        // I and D together: D first, I accepted the cycle after d_rsp_valid
        d_req_valid = 1'b1; d_req_addr = 32'h0100_0100; d_req_rw = MEM_READ; d_req_size = LS_W;
        i_req_valid = 1'b1; i_req_addr = 32'h0100_0004;
        cyc();
        chk("t2_d_first", saw_d_acc, 1'b1);
        chk("t2_i_held", saw_i_acc, 1'b0);
        d_req_valid = 1'b0;
        rsp_at = -100; acc_at = 0; k = 0;
        while (acc_at == 0 && k < 20) begin
            cyc();
            if (saw_d_rsp) rsp_at = cyc_n;
            if (saw_i_acc) acc_at = cyc_n;
            k++;
        end
        chk("t2_i_after_d_rsp", acc_at - rsp_at, 1);
        i_req_valid = 1'b0;
        drain("t2_drain");

        // store with 3 stall cycles and a stray response during REQ
        stall_knob = 3;
        i0 = i_rsp_cnt; d0 = d_rsp_cnt;
        d_req_valid = 1'b1; d_req_addr = 32'h0100_0200; d_req_wdata = 32'hDEAD_BEEF;
        d_req_rw = MEM_WRITE; d_req_size = LS_W;
        cyc();
        chk("t3_accept", saw_d_acc, 1'b1);
        d_req_valid = 1'b0;
        spur_knob = 1'b1;
        drain("t3_drain");
        chk("t3_one_d_rsp", d_rsp_cnt - d0, 1);
        chk("t3_no_i_rsp", i_rsp_cnt - i0, 0);
        stall_knob = 0;

        // reset during WAIT, memory answers afterwards
        lat_knob = 3;
        d_req_valid = 1'b1; d_req_addr = 32'h0100_0200; d_req_rw = MEM_READ;
        cyc();
        d_req_valid = 1'b0;
        k = 0;
        while (!issued && k < 20) begin
            cyc();
            k++;
        end
        chk("t4_in_wait", busy, 1'b1);
        i0 = i_rsp_cnt; d0 = d_rsp_cnt; m0 = m_rsp_cnt;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (6) cyc();
        chk("t4_late_m_rsp_seen", (m_rsp_cnt - m0) >= 1, 1'b1);
        chk("t4_no_rsp_pulse", (i_rsp_cnt - i0) + (d_rsp_cnt - d0), 0);
        chk("t4_busy", busy, 1'b0);
        lat_knob = 0;

        // stray response in IDLE
        i0 = i_rsp_cnt; d0 = d_rsp_cnt;
        spur_knob = 1'b1;
        cyc();
        cyc();
        chk("t5_no_rsp_pulse", (i_rsp_cnt - i0) + (d_rsp_cnt - d0), 0);
        chk("t5_idle", busy, 1'b0);

        // both requesters valid continuously
        g0 = grant_log.size();
        i_req_valid = 1'b1; i_req_addr = 32'h0100_0040;
        d_req_valid = 1'b1; d_req_addr = 32'h0100_0080; d_req_rw = MEM_READ;
        k = 0;
        while (grant_log.size() - g0 < 10 && k < 300) begin
            cyc();
            if (saw_i_acc) i_req_addr = i_req_addr + 32'd4;
            if (saw_d_acc) d_req_addr = d_req_addr + 32'd4;
            k++;
        end
        for (int g = 0; g < 10; g++) begin
            int got, exp_g;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_g = ((g % (LIMIT + 1)) == LIMIT) ? 0 : 1;
`else
            exp_g = 1;
`endif
            got = (g0 + g < grant_log.size()) ? grant_log[g0 + g] : 9;
            chk("t6_grant_seq", got, exp_g);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        drain("t6_drain");

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            stall_knob = $urandom_range(0, 2);
            lat_knob   = $urandom_range(0, 2);
            if (!i_req_valid && $urandom_range(0, 3) == 0) begin
                i_req_valid = 1'b1;
                i_req_addr  = 32'h0100_0000 | (32'($urandom_range(0, 31)) << 2);
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1'b1;
                d_req_addr  = 32'h0100_0000 | (32'($urandom_range(0, 31)) << 2);
                d_req_wdata = $urandom;
                d_req_rw    = 1'($urandom_range(0, 1));
                d_req_size  = 2'($urandom_range(0, 2));
            end
            cyc();
            if (saw_i_acc) i_req_valid = 1'b0;
            if (saw_d_acc) d_req_valid = 1'b0;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        stall_knob = 0; lat_knob = 0;
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
